// File: rtl/flash_line_arbiter_pkg.sv
// Shared definitions for the flash line arbiter: FSM encoding, default sizes
// and the line-alignment helper used for reader addresses and merge compares.
package flash_line_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_DELIVER = 2'd3
    } state_t;

    localparam int LINE_SIZE_DEF = 128;
    localparam int ADDR_W        = 24;
    localparam int TIMER_W       = 8;

    // Clears the byte-within-line bits so only the line number remains.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a, input int ofs);
        logic [ADDR_W-1:0] mask;
        mask = ~((ADDR_W'(1) << ofs) - ADDR_W'(1));
        return a & mask;
    endfunction

endpackage

// File: rtl/flash_line_arbiter_prio.sv
// Two-requester priority decision: r0 normally wins, r1 wins once it has lost
// STARVE_LIMIT consecutive arbitrations while pending.
module flash_arb_prio #(
    parameter int STARVE_LIMIT = 2,
    parameter int SW           = 2
) (
    input  logic          i_pend_0,
    input  logic          i_pend_1,
    input  logic [SW-1:0] i_starve,
    output logic          o_win_r1,
    output logic [SW-1:0] o_starve_nxt
);

    logic w_starved;

    assign w_starved = (i_starve == SW'(STARVE_LIMIT));

    always_comb begin
        o_win_r1     = i_pend_1 && (w_starved || !i_pend_0);
        o_starve_nxt = i_starve;
        if (i_pend_1) begin
            if (o_win_r1) begin
                o_starve_nxt = '0;
            end else if (!w_starved) begin
                o_starve_nxt = i_starve + SW'(1);
            end
        end
    end

endmodule

// File: rtl/flash_line_arbiter.sv
// Shares one flash line reader between an I-cache miss path (r0) and a
// data/prefetch path (r1), merging requests that target the same line.
module flash_line_arbiter
    import flash_line_arbiter_pkg::*;
#(
    parameter int LINE_SIZE    = LINE_SIZE_DEF,
    parameter int STARVE_LIMIT = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 r0_req,
    input  logic [ADDR_W-1:0]    r0_addr,
    output logic                 r0_busy,
    output logic                 r0_done,
    input  logic                 r1_req,
    input  logic [ADDR_W-1:0]    r1_addr,
    output logic                 r1_busy,
    output logic                 r1_done,
    output logic [LINE_SIZE-1:0] line_o,
    output logic                 err,
    output logic [ADDR_W-1:0]    fr_addr,
    output logic                 fr_rd,
    input  logic                 fr_done,
    input  logic [LINE_SIZE-1:0] fr_line,
    output state_t               o_dbg_state
);

    localparam int OFS = $clog2(LINE_SIZE / 8);
    localparam int SW  = $clog2(STARVE_LIMIT + 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_pend_0;
    logic                  r_pend_1;
    logic [ADDR_W-1:0]     r_addr_0;
    logic [ADDR_W-1:0]     r_addr_1;
    logic                  r_win_r1;
    logic [SW-1:0]         r_starve;
    logic [TIMER_W-1:0]    r_timer;
    logic [LINE_SIZE-1:0]  r_line;
    logic [ADDR_W-1:0]     r_fr_addr;
    logic                  r_err;

    logic                  w_arb;
    logic                  w_win_r1;
    logic [SW-1:0]         w_starve_nxt;
    logic                  w_same_line;
    logic                  w_merge;
    logic                  w_done_0;
    logic                  w_done_1;
    logic                  w_abort;

    flash_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .SW           (SW)
    ) u_prio (
        .i_pend_0     (r_pend_0),
        .i_pend_1     (r_pend_1),
        .i_starve     (r_starve),
        .o_win_r1     (w_win_r1),
        .o_starve_nxt (w_starve_nxt)
    );

    assign w_arb       = (r_state == ST_IDLE) && (r_pend_0 || r_pend_1);
    assign w_same_line = (line_align(r_addr_0, OFS) == line_align(r_addr_1, OFS));
    assign w_merge     = (r_state == ST_DELIVER) && (r_win_r1 ? r_pend_0 : r_pend_1) && w_same_line;
    assign w_done_0    = (r_state == ST_DELIVER) && (!r_win_r1 || w_merge);
    assign w_done_1    = (r_state == ST_DELIVER) && (r_win_r1 || w_merge);
    assign w_abort     = (r_state == ST_BUSY) && !fr_done && (r_timer == TIMER_W'(TIMEOUT));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_arb) w_state_nxt = ST_ISSUE;
            ST_ISSUE:   w_state_nxt = ST_BUSY;
            ST_BUSY: begin
                if (fr_done)      w_state_nxt = ST_DELIVER;
                else if (w_abort) w_state_nxt = ST_IDLE;
            end
            ST_DELIVER: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // A new request in the same cycle as its done is accepted: set beats clear.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_pend_0 <= 1'b0;
            r_pend_1 <= 1'b0;
            r_addr_0 <= '0;
            r_addr_1 <= '0;
        end else begin
            if (r0_req && (!r_pend_0 || w_done_0)) begin
                r_pend_0 <= 1'b1;
                r_addr_0 <= r0_addr;
            end else if (w_done_0) begin
                r_pend_0 <= 1'b0;
            end
            if (r1_req && (!r_pend_1 || w_done_1)) begin
                r_pend_1 <= 1'b1;
                r_addr_1 <= r1_addr;
            end else if (w_done_1) begin
                r_pend_1 <= 1'b0;
            end
        end
    end

    // The reader address is loaded on the way into ISSUE so it is stable while fr_rd is high.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state   <= ST_IDLE;
            r_win_r1  <= 1'b0;
            r_starve  <= '0;
            r_timer   <= '0;
            r_line    <= '0;
            r_fr_addr <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_abort;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb) begin
                        r_win_r1  <= w_win_r1;
                        r_starve  <= w_starve_nxt;
                        r_fr_addr <= line_align(w_win_r1 ? r_addr_1 : r_addr_0, OFS);
                    end
                end
                ST_ISSUE: r_timer <= '0;
                ST_BUSY: begin
                    if (fr_done)       r_line  <= fr_line;
                    else if (!w_abort) r_timer <= r_timer + TIMER_W'(1);
                end
                ST_DELIVER: begin
                    if (w_merge && !r_win_r1) r_starve <= '0;
                end
                default: ;
            endcase
        end
    end

    assign r0_busy     = r_pend_0;
    assign r1_busy     = r_pend_1;
    assign r0_done     = w_done_0;
    assign r1_done     = w_done_1;
    assign line_o      = r_line;
    assign err         = r_err;
    assign fr_addr     = r_fr_addr;
    assign fr_rd       = (r_state == ST_ISSUE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_flash_line_arbiter.sv
// Directed bench for flash_line_arbiter: arbitration order, starvation relief,
// same-line merge, reader timeout retry and asynchronous reset.
module tb_flash_line_arbiter;
    import flash_line_arbiter_pkg::*;

    logic         HCLK = 1'b0;
    logic         HRESETn;
    logic         r0_req, r1_req;
    logic [23:0]  r0_addr, r1_addr;
    logic         r0_busy, r0_done, r1_busy, r1_done;
    logic [127:0] line_o;
    logic         err;
    logic [23:0]  fr_addr;
    logic         fr_rd;
    logic         fr_done;
    logic [127:0] fr_line;
    state_t       o_dbg_state;

    int n_vec = 0;
    int n_err = 0;

    flash_line_arbiter dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .r0_req      (r0_req),
        .r0_addr     (r0_addr),
        .r0_busy     (r0_busy),
        .r0_done     (r0_done),
        .r1_req      (r1_req),
        .r1_addr     (r1_addr),
        .r1_busy     (r1_busy),
        .r1_done     (r1_done),
        .line_o      (line_o),
        .err         (err),
        .fr_addr     (fr_addr),
        .fr_rd       (fr_rd),
        .fr_done     (fr_done),
        .fr_line     (fr_line),
        .o_dbg_state (o_dbg_state)
    );

    always #5 HCLK = ~HCLK;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic wait_rd(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (fr_rd) begin
                seen = 1'b1;
                break;
            end
            step();
        end
    endtask

    // From the ISSUE cycle: one BUSY cycle, then fr_done; returns in the DELIVER cycle.
    task automatic serve(input logic [127:0] l);
        step();
        fr_done = 1'b1;
        fr_line = l;
        step();
        fr_done = 1'b0;
        fr_line = '0;
    endtask

    task automatic test_reset();
        n_vec++; if (r0_busy !== 1'b0) begin n_err++; $display("FAIL reset_r0_busy got %0b want 0", r0_busy); end
        n_vec++; if (r1_busy !== 1'b0) begin n_err++; $display("FAIL reset_r1_busy got %0b want 0", r1_busy); end
        n_vec++; if (fr_rd !== 1'b0) begin n_err++; $display("FAIL reset_fr_rd got %0b want 0", fr_rd); end
        n_vec++; if (fr_addr !== 24'h0) begin n_err++; $display("FAIL reset_fr_addr got %h want 0", fr_addr); end
        n_vec++; if (line_o !== 128'h0) begin n_err++; $display("FAIL reset_line_o got %h want 0", line_o); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got %0b want 0", err); end
        n_vec++; if (o_dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state got %0d want 0", o_dbg_state); end
    endtask

    task automatic test_single();
        r0_req = 1'b1; r0_addr = 24'h000104;
        step();
        r0_req = 1'b0;
        n_vec++; if (r0_busy !== 1'b1) begin n_err++; $display("FAIL t1_busy got %0b want 1", r0_busy); end
        n_vec++; if (fr_rd !== 1'b0) begin n_err++; $display("FAIL t1_rd_early got %0b want 0", fr_rd); end
        step();
        n_vec++; if (fr_rd !== 1'b1) begin n_err++; $display("FAIL t1_rd got %0b want 1", fr_rd); end
        n_vec++; if (fr_addr !== 24'h000100) begin n_err++; $display("FAIL t1_addr got %h want 000100", fr_addr); end
        step();
        n_vec++; if (fr_rd !== 1'b0) begin n_err++; $display("FAIL t1_rd_busy got %0b want 0", fr_rd); end
        fr_done = 1'b1; fr_line = {4{32'h11223344}};
        step();
        fr_done = 1'b0; fr_line = '0;
        n_vec++; if (r0_done !== 1'b1) begin n_err++; $display("FAIL t1_done got %0b want 1", r0_done); end
        n_vec++; if (r1_done !== 1'b0) begin n_err++; $display("FAIL t1_r1_done got %0b want 0", r1_done); end
        n_vec++; if (line_o !== {4{32'h11223344}}) begin n_err++; $display("FAIL t1_line got %h want %h", line_o, {4{32'h11223344}}); end
        step();
        n_vec++; if (r0_done !== 1'b0) begin n_err++; $display("FAIL t1_done_pulse got %0b want 0", r0_done); end
        n_vec++; if (r0_busy !== 1'b0) begin n_err++; $display("FAIL t1_busy_drop got %0b want 0", r0_busy); end
        n_vec++; if (line_o !== {4{32'h11223344}}) begin n_err++; $display("FAIL t1_line_hold got %h", line_o); end
    endtask

    task automatic test_priority();
        bit seen;
        r0_req = 1'b1; r0_addr = 24'h000200;
        r1_req = 1'b1; r1_addr = 24'h000300;
        step();
        r0_req = 1'b0; r1_req = 1'b0;
        wait_rd(8, seen);
        n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL t2_rd0 timeout got 0 want 1"); end
        n_vec++; if (fr_addr !== 24'h000200) begin n_err++; $display("FAIL t2_addr0 got %h want 000200", fr_addr); end
        serve({4{32'hA0A0A0A0}});
        n_vec++; if ({r0_done, r1_done} !== 2'b10) begin n_err++; $display("FAIL t2_done0 got %b want 10", {r0_done, r1_done}); end
        step();
        wait_rd(8, seen);
        n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL t2_rd1 timeout got 0 want 1"); end
        n_vec++; if (fr_addr !== 24'h000300) begin n_err++; $display("FAIL t2_addr1 got %h want 000300", fr_addr); end
        serve({4{32'hB1B1B1B1}});
        n_vec++; if ({r0_done, r1_done} !== 2'b01) begin n_err++; $display("FAIL t2_done1 got %b want 01", {r0_done, r1_done}); end
        n_vec++; if (line_o !== {4{32'hB1B1B1B1}}) begin n_err++; $display("FAIL t2_line got %h", line_o); end
        step();
        n_vec++; if (r1_busy !== 1'b0) begin n_err++; $display("FAIL t2_r1_busy got %0b want 0", r1_busy); end
    endtask

    task automatic test_starve();
        bit seen;
        logic [23:0] exp_addr [4];
        exp_addr[0] = 24'h000500; exp_addr[1] = 24'h000600;
        exp_addr[2] = 24'h000400; exp_addr[3] = 24'h000700;
        r0_req = 1'b1; r0_addr = 24'h000500;
        r1_req = 1'b1; r1_addr = 24'h000400;
        step();
        r0_req = 1'b0; r1_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_rd(8, seen);
            n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL t3_rd%0d timeout got 0 want 1", k); end
            n_vec++; if (fr_addr !== exp_addr[k]) begin n_err++; $display("FAIL t3_addr%0d got %h want %h", k, fr_addr, exp_addr[k]); end
            serve(128'(k + 1));
            n_vec++;
            if ({r0_done, r1_done} !== ((k == 2) ? 2'b01 : 2'b10)) begin
                n_err++; $display("FAIL t3_done%0d got %b want %b", k, {r0_done, r1_done}, (k == 2) ? 2'b01 : 2'b10);
            end
            if (k < 2) begin
                r0_req = 1'b1; r0_addr = 24'h000600 + 24'(k) * 24'h100;
            end
            step();
            r0_req = 1'b0;
        end
        n_vec++; if ({r0_busy, r1_busy} !== 2'b00) begin n_err++; $display("FAIL t3_drain got %b want 00", {r0_busy, r1_busy}); end
    endtask

    task automatic test_merge();
        bit seen;
        int rd_count;
        r0_req = 1'b1; r0_addr = 24'h000010;
        r1_req = 1'b1; r1_addr = 24'h00001C;
        step();
        r0_req = 1'b0; r1_req = 1'b0;
        wait_rd(8, seen);
        n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL t4_rd timeout got 0 want 1"); end
        n_vec++; if (fr_addr !== 24'h000010) begin n_err++; $display("FAIL t4_addr got %h want 000010", fr_addr); end
        serve({4{32'hC3C3C3C3}});
        n_vec++; if ({r0_done, r1_done} !== 2'b11) begin n_err++; $display("FAIL t4_done got %b want 11", {r0_done, r1_done}); end
        rd_count = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (fr_rd) rd_count++;
        end
        n_vec++; if (rd_count !== 0) begin n_err++; $display("FAIL t4_extra_rd got %0d want 0", rd_count); end
        n_vec++; if ({r0_busy, r1_busy} !== 2'b00) begin n_err++; $display("FAIL t4_busy got %b want 00", {r0_busy, r1_busy}); end
    endtask

    task automatic test_timeout();
        bit seen;
        int n_cyc;
        int rd_count;
        r0_req = 1'b1; r0_addr = 24'h000A48;
        step();
        r0_req = 1'b0;
        wait_rd(8, seen);
        n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL t5_rd timeout got 0 want 1"); end
        // ISSUE, then 256 BUSY cycles (timer 0..255), err visible in the following IDLE cycle.
        n_cyc = 0;
        rd_count = 0;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (fr_rd) rd_count++;
            if (err) begin
                n_cyc = i;
                break;
            end
        end
        n_vec++; if (n_cyc !== 257) begin n_err++; $display("FAIL t5_err_cycle got %0d want 257", n_cyc); end
        n_vec++; if (rd_count !== 0) begin n_err++; $display("FAIL t5_rd_in_busy got %0d want 0", rd_count); end
        n_vec++; if (r0_busy !== 1'b1) begin n_err++; $display("FAIL t5_pend_kept got %0b want 1", r0_busy); end
        step();
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL t5_err_pulse got %0b want 0", err); end
        n_vec++; if (fr_rd !== 1'b1) begin n_err++; $display("FAIL t5_retry_rd got %0b want 1", fr_rd); end
        n_vec++; if (fr_addr !== 24'h000A40) begin n_err++; $display("FAIL t5_retry_addr got %h want 000A40", fr_addr); end
        serve({4{32'h5A5A5A5A}});
        n_vec++; if (r0_done !== 1'b1) begin n_err++; $display("FAIL t5_done got %0b want 1", r0_done); end
        step();
    endtask

    task automatic test_async_reset();
        bit seen;
        r1_req = 1'b1; r1_addr = 24'h123456;
        step();
        r1_req = 1'b0;
        wait_rd(8, seen);
        n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL t6_rd timeout got 0 want 1"); end
        step();
        step();
        #2 HRESETn = 1'b0;
        #1;
        n_vec++; if (r1_busy !== 1'b0) begin n_err++; $display("FAIL t6_busy got %0b want 0", r1_busy); end
        n_vec++; if (fr_addr !== 24'h0) begin n_err++; $display("FAIL t6_addr got %h want 0", fr_addr); end
        n_vec++; if (line_o !== 128'h0) begin n_err++; $display("FAIL t6_line got %h want 0", line_o); end
        n_vec++; if (o_dbg_state !== ST_IDLE) begin n_err++; $display("FAIL t6_state got %0d want 0", o_dbg_state); end
        step();
        HRESETn = 1'b1;
        fr_done = 1'b1; fr_line = {4{32'hDEADBEEF}};
        step();
        fr_done = 1'b0; fr_line = '0;
        n_vec++; if ({r0_done, r1_done} !== 2'b00) begin n_err++; $display("FAIL t6_late_done got %b want 00", {r0_done, r1_done}); end
        n_vec++; if (line_o !== 128'h0) begin n_err++; $display("FAIL t6_late_line got %h want 0", line_o); end
        n_vec++; if (o_dbg_state !== ST_IDLE) begin n_err++; $display("FAIL t6_late_state got %0d want 0", o_dbg_state); end
    endtask

    initial begin
        HRESETn = 1'b0;
        r0_req = 1'b0; r0_addr = '0;
        r1_req = 1'b0; r1_addr = '0;
        fr_done = 1'b0; fr_line = '0;
        step();
        step();
        test_reset();
        HRESETn = 1'b1;
        step();
        test_single();
        test_priority();
        test_starve();
        test_merge();
        test_timeout();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
